// File: rtl/adbg_or1k_bp_pkg.sv
// Shared types and constants for the OR1K hardware breakpoint/watchpoint unit.
package adbg_or1k_bp_pkg;

    typedef enum logic [2:0] {
        COND_EQ  = 3'd0,
        COND_NE  = 3'd1,
        COND_LTU = 3'd2,
        COND_LEU = 3'd3,
        COND_GTU = 3'd4,
        COND_GEU = 3'd5,
        COND_NV6 = 3'd6,
        COND_NV7 = 3'd7
    } bp_cond_e;

    typedef enum logic [1:0] {
        SRC_PC    = 2'd0,
        SRC_LOAD  = 2'd1,
        SRC_STORE = 2'd2,
        SRC_LSU   = 2'd3
    } bp_src_e;

    // CTRL_k field layout
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_COND_LSB  = 1;
    localparam int CTRL_COND_W    = 3;
    localparam int CTRL_SRC_LSB   = 4;
    localparam int CTRL_SRC_W     = 2;
    localparam int CTRL_CHAIN_BIT = 6;
    localparam int CTRL_W         = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRE  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ARMED = ST_ARMED,
        S_FIRE  = ST_FIRE,
        S_HALT  = ST_HALT
    } bp_state_e;

    // Register index helpers: VAL_k/CTRL_k interleaved, then THRESH and STATUS.
    function automatic int val_idx(input int k);
        return 2 * k;
    endfunction

    function automatic int ctrl_idx(input int k);
        return 2 * k + 1;
    endfunction

    function automatic int thresh_idx(input int n);
        return 2 * n;
    endfunction

    function automatic int status_idx(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/adbg_or1k_bp_cmp.sv
// One address comparator: operand select, source qualification, unsigned compare.
module adbg_or1k_bp_cmp
    import adbg_or1k_bp_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic                   en_i,
    input  logic [CTRL_COND_W-1:0] cond_i,
    input  logic [CTRL_SRC_W-1:0]  src_i,
    input  logic [AW-1:0]          val_i,
    input  logic                   ex_valid_i,
    input  logic [AW-1:0]          ex_pc_i,
    input  logic                   lsu_valid_i,
    input  logic                   lsu_we_i,
    input  logic [AW-1:0]          lsu_addr_i,
    output logic                   raw_o
);

    logic [AW-1:0] opnd;
    logic          src_valid;
    logic          cond_ok;

    // Select the operand, qualify it by its source, and evaluate the condition.
    always_comb begin
        opnd      = (src_i == SRC_PC) ? ex_pc_i : lsu_addr_i;
        src_valid = 1'b0;
        cond_ok   = 1'b0;
        case (src_i)
            SRC_PC:    src_valid = ex_valid_i;
            SRC_LOAD:  src_valid = lsu_valid_i & ~lsu_we_i;
            SRC_STORE: src_valid = lsu_valid_i & lsu_we_i;
            default:   src_valid = lsu_valid_i;
        endcase
        case (cond_i)
            COND_EQ:  cond_ok = (opnd == val_i);
            COND_NE:  cond_ok = (opnd != val_i);
            COND_LTU: cond_ok = (opnd <  val_i);
            COND_LEU: cond_ok = (opnd <= val_i);
            COND_GTU: cond_ok = (opnd >  val_i);
            COND_GEU: cond_ok = (opnd >= val_i);
            default:  cond_ok = 1'b0;
        endcase
        raw_o = en_i & src_valid & cond_ok;
    end

endmodule

// File: rtl/adbg_or1k_bp_unit.sv
// OR1K breakpoint/watchpoint unit: register file, comparator chaining,
// hit counter and the fire/halt sequencer feeding the debug status register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no comparator enabled, events ignored
// S_ARMED | counting qualifying events toward THRESH
// S_FIRE  | one-cycle bp_o pulse
// S_HALT  | waiting for the stall to be raised and released
module adbg_or1k_bp_unit
    import adbg_or1k_bp_pkg::*;
#(
    parameter int NUM_WP = 4,
    parameter int AW     = 32,
    parameter int CNT_W  = 16
) (
    input  logic                              cpu_clk_i,
    input  logic                              rst_i,
    input  logic                              cfg_we_i,
    input  logic [$clog2(2*NUM_WP+2)-1:0]     cfg_addr_i,
    input  logic [AW-1:0]                     cfg_wdata_i,
    output logic [AW-1:0]                     cfg_rdata_o,
    input  logic                              ex_valid_i,
    input  logic [AW-1:0]                     ex_pc_i,
    input  logic                              lsu_valid_i,
    input  logic                              lsu_we_i,
    input  logic [AW-1:0]                     lsu_addr_i,
    input  logic                              stall_i,
    output logic                              bp_o
);

    localparam int RAW = $clog2(2*NUM_WP+2);

    logic [AW-1:0]     val_q  [NUM_WP];
    logic [CTRL_W-1:0] ctrl_q [NUM_WP];
    logic [CNT_W-1:0]  thresh_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_WP-1:0] flags_q, flags_d;
    bp_state_e         state_q, state_d;
    logic              stall_q;

    logic [NUM_WP-1:0] raw, eff, trig, en_vec, succ_chain;
    logic              any_en, ev, fire, halted;
    logic              thresh_we, status_we;
    logic [CNT_W:0]    cnt_inc, thr_eff;

    assign thresh_we = cfg_we_i && (cfg_addr_i == RAW'(thresh_idx(NUM_WP)));
    assign status_we = cfg_we_i && (cfg_addr_i == RAW'(status_idx(NUM_WP)));

    // Configuration registers; writes become visible the following cycle.
    always_ff @(posedge cpu_clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_WP; k++) begin
                val_q[k]  <= '0;
                ctrl_q[k] <= '0;
            end
            thresh_q <= '0;
        end else if (cfg_we_i) begin
            for (int k = 0; k < NUM_WP; k++) begin
                if (cfg_addr_i == RAW'(val_idx(k)))  val_q[k]  <= cfg_wdata_i;
                if (cfg_addr_i == RAW'(ctrl_idx(k))) ctrl_q[k] <= cfg_wdata_i[CTRL_W-1:0];
            end
            if (thresh_we) thresh_q <= cfg_wdata_i[CNT_W-1:0];
        end
    end

    for (genvar g = 0; g < NUM_WP; g++) begin : g_cmp
        adbg_or1k_bp_cmp #(.AW(AW)) u_cmp (
            .en_i       (ctrl_q[g][CTRL_EN_BIT]),
            .cond_i     (ctrl_q[g][CTRL_COND_LSB +: CTRL_COND_W]),
            .src_i      (ctrl_q[g][CTRL_SRC_LSB +: CTRL_SRC_W]),
            .val_i      (val_q[g]),
            .ex_valid_i (ex_valid_i),
            .ex_pc_i    (ex_pc_i),
            .lsu_valid_i(lsu_valid_i),
            .lsu_we_i   (lsu_we_i),
            .lsu_addr_i (lsu_addr_i),
            .raw_o      (raw[g])
        );
    end

    // Chain qualification; a comparator feeding a chained successor only
    // contributes through that successor.
    always_comb begin
        logic prev;
        prev       = 1'b0;
        eff        = '0;
        trig       = '0;
        en_vec     = '0;
        succ_chain = '0;
        for (int k = 0; k < NUM_WP - 1; k++) begin
            succ_chain[k] = ctrl_q[k+1][CTRL_CHAIN_BIT];
        end
        for (int k = 0; k < NUM_WP; k++) begin
            en_vec[k] = ctrl_q[k][CTRL_EN_BIT];
            eff[k]    = raw[k] & ((k != 0 && ctrl_q[k][CTRL_CHAIN_BIT]) ? prev : 1'b1);
            prev      = eff[k];
            trig[k]   = eff[k] & ~succ_chain[k];
        end
        any_en = |en_vec;
        ev     = |trig;
    end

    // Next-state, hit counter and sticky flag logic.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
        thr_eff = (thresh_q == '0) ? (CNT_W+1)'(1) : {1'b0, thresh_q};
        fire    = (state_q == S_ARMED) && ev && (cnt_inc >= thr_eff);
        state_d = state_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE:  if (any_en) state_d = S_ARMED;
            S_ARMED: begin
                if (fire)         state_d = S_FIRE;
                else if (!any_en) state_d = S_IDLE;
            end
            S_FIRE:  state_d = S_HALT;
            S_HALT:  if (stall_q && !stall_i) state_d = any_en ? S_ARMED : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (thresh_we || fire) begin
            cnt_d = '0;
        end else if (state_q == S_ARMED && ev && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (fire)           flags_d = eff;
        else if (status_we) flags_d = '0;
    end

    // Sequencer state, counter, flags and the stall edge register.
    always_ff @(posedge cpu_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            flags_q <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            stall_q <= stall_i;
        end
    end

    assign halted = (state_q == S_FIRE) || (state_q == S_HALT);
    assign bp_o   = (state_q == S_FIRE);

    // Combinational register readback; unmapped indices read zero.
    always_comb begin
        cfg_rdata_o = '0;
        for (int k = 0; k < NUM_WP; k++) begin
            if (cfg_addr_i == RAW'(val_idx(k)))  cfg_rdata_o = val_q[k];
            if (cfg_addr_i == RAW'(ctrl_idx(k))) cfg_rdata_o = AW'(ctrl_q[k]);
        end
        if (cfg_addr_i == RAW'(thresh_idx(NUM_WP))) cfg_rdata_o = AW'(thresh_q);
        if (cfg_addr_i == RAW'(status_idx(NUM_WP))) cfg_rdata_o = AW'({halted, flags_q});
    end

endmodule

// File: tb/tb_adbg_or1k_bp_unit.sv
// Scoreboard bench for adbg_or1k_bp_unit: stimulus queues expected pulses and
// read values, a negedge monitor pops and compares them.
module tb_adbg_or1k_bp_unit;

    localparam logic [3:0] A_VAL0  = 4'd0;
    localparam logic [3:0] A_CTRL0 = 4'd1;
    localparam logic [3:0] A_VAL1  = 4'd2;
    localparam logic [3:0] A_CTRL1 = 4'd3;
    localparam logic [3:0] A_THR   = 4'd8;
    localparam logic [3:0] A_STAT  = 4'd9;

    logic        cpu_clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        lsu_valid_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic        stall_i;
    logic        bp_o;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        rd_stb;
    logic        done;
    int          bp_q[$];
    logic [31:0] rd_q[$];
    string       nm_q[$];

    adbg_or1k_bp_unit #(.NUM_WP(4), .AW(32), .CNT_W(16)) dut (
        .cpu_clk_i  (cpu_clk_i),
        .rst_i      (rst_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_addr_i (cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o),
        .ex_valid_i (ex_valid_i),
        .ex_pc_i    (ex_pc_i),
        .lsu_valid_i(lsu_valid_i),
        .lsu_we_i   (lsu_we_i),
        .lsu_addr_i (lsu_addr_i),
        .stall_i    (stall_i),
        .bp_o       (bp_o)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;
    always @(posedge cpu_clk_i) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, got timeout want done");
        $fatal(1);
    end

    // Monitor: compare pulses against expected cycles and reads against expected data.
    always @(negedge cpu_clk_i) begin
        if (bp_q.size() > 0 && bp_q[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL bp_missed: got no pulse want pulse at cycle %0d", bp_q[0]);
            void'(bp_q.pop_front());
        end
        if (bp_o) begin
            total++;
            if (bp_q.size() > 0 && bp_q[0] == cyc) begin
                void'(bp_q.pop_front());
            end else begin
                bad++;
                $display("FAIL bp_unexpected: got pulse at cycle %0d want none", cyc);
            end
        end
        if (rd_stb) begin
            logic [31:0] e;
            string       n;
            e = rd_q.pop_front();
            n = nm_q.pop_front();
            total++;
            if (cfg_rdata_o !== e) begin
                bad++;
                $display("FAIL %s: got %h want %h", n, cfg_rdata_o, e);
            end
        end
        if (done) begin
            total++;
            if (bp_q.size() != 0) begin
                bad++;
                $display("FAIL bp_pending: got %0d outstanding want 0", bp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge cpu_clk_i);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        cfg_addr_i = a;
        rd_q.push_back(e);
        nm_q.push_back(n);
        rd_stb = 1'b1;
        tick();
        rd_stb = 1'b0;
    endtask

    task automatic step(input logic exv, input logic [31:0] pc, input logic lv,
                        input logic lwe, input logic [31:0] la, input logic exp);
        ex_valid_i  = exv;
        ex_pc_i     = pc;
        lsu_valid_i = lv;
        lsu_we_i    = lwe;
        lsu_addr_i  = la;
        if (exp) bp_q.push_back(cyc + 1);
        tick();
        ex_valid_i  = 1'b0;
        lsu_valid_i = 1'b0;
        lsu_we_i    = 1'b0;
    endtask

    task automatic release_stall();
        stall_i = 1'b1;
        tick();
        tick();
        stall_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
        ex_valid_i = 1'b0; ex_pc_i = '0; lsu_valid_i = 1'b0; lsu_we_i = 1'b0;
        lsu_addr_i = '0; stall_i = 1'b0; rd_stb = 1'b0; done = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tick();

        // Reset state
        rd(A_VAL0, 32'h0, "rst_val0");
        rd(A_CTRL0, 32'h0, "rst_ctrl0");
        rd(A_THR, 32'h0, "rst_thresh");
        rd(A_STAT, 32'h0, "rst_status");

        // Single PC hit, THRESH=0
        wr(A_VAL0, 32'h100);
        wr(A_CTRL0, 32'h01);
        wr(A_THR, 32'h0);
        tick();
        rd(A_CTRL0, 32'h01, "ctrl0_rb");
        step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        rd(A_STAT, 32'h11, "status_pc_hit");

        // No re-fire while stalled; re-fire one cycle after the stall drops
        stall_i = 1'b1;
        tick();
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        stall_i = 1'b0;
        tick();
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        release_stall();
        wr(A_STAT, 32'h0);
        rd(A_STAT, 32'h0, "status_cleared");

        // Threshold 3 with counter clears (plain write and write coinciding with a hit)
        wr(A_THR, 32'h3);
        rd(A_THR, 32'h3, "thresh_rb");
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        wr(A_THR, 32'h3);
        cfg_we_i = 1'b1; cfg_addr_i = A_THR; cfg_wdata_i = 32'h3;
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        cfg_we_i = 1'b0;
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        rd(A_STAT, 32'h11, "status_thresh");
        release_stall();
        wr(A_STAT, 32'h0);
        wr(A_CTRL0, 32'h0);
        wr(A_THR, 32'h0);

        // GEU store watchpoint on comparator 1
        wr(A_VAL1, 32'h8000_0000);
        wr(A_CTRL1, 32'h2B);
        tick(); tick();
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h9000_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h7000_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h9000_0000, 1'b1);
        tick();
        rd(A_STAT, 32'h12, "status_geu");
        rd(A_VAL1, 32'h8000_0000, "val1_rb");
        release_stall();
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, 1'b1);
        tick();
        release_stall();
        wr(A_STAT, 32'h0);
        wr(A_CTRL1, 32'h0);

        // Chained pair: PC 0x200 and store 0x300 in the same cycle
        wr(A_VAL0, 32'h200);
        wr(A_CTRL0, 32'h01);
        wr(A_VAL1, 32'h300);
        wr(A_CTRL1, 32'h61);
        tick(); tick();
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b0);
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h200, 1'b1, 1'b1, 32'h300, 1'b1);
        tick();
        rd(A_STAT, 32'h13, "status_chain");
        rd(4'd12, 32'h0, "unmapped");

        // Reset while halted
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        rd(A_VAL0, 32'h0, "rst2_val0");
        rd(A_CTRL0, 32'h0, "rst2_ctrl0");
        rd(A_VAL1, 32'h0, "rst2_val1");
        rd(A_CTRL1, 32'h0, "rst2_ctrl1");
        rd(A_STAT, 32'h0, "rst2_status");
        step(1'b1, 32'h200, 1'b1, 1'b1, 32'h300, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(); tick(); tick();
        done = 1'b1;
    end

endmodule
